utmi_rx: RTL and testbench



---
 rtl/utmi_rx.sv | 151 +++++++++++++++
 tb/tb_utmi_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/utmi_rx.sv
// UTMI+ receive adapter: turns the PHY byte stream into sop/eop-framed link beats.
// A one-byte hold register lets eop land on the last byte; a small FIFO absorbs downstream stalls.
module utmi_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       i_utmi_rx_clk,
  input  logic       i_utmi_rx_rst_n,
  input  logic       i_utmi_rx_rxactive,
  input  logic       i_utmi_rx_rxvalid,
  input  logic       i_utmi_rx_rxerror,
  input  logic [7:0] i_utmi_rx_data,
  input  logic       i_utmi_rx_lp_ready,
  output logic [7:0] o_utmi_rx_lp_data,
  output logic       o_utmi_rx_lp_sop,
  output logic       o_utmi_rx_lp_eop,
  output logic       o_utmi_rx_lp_valid,
  output logic       o_utmi_rx_pkt_error,
  output logic       o_utmi_rx_overflow,
  output logic       o_utmi_rx_busy
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t             state;
  logic               rxactive_d;
  logic               armed;
  logic               first_flag;
  logic               h_valid;
  logic               h_sop;
  logic [7:0]         h_data;
  logic [9:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   wr_ptr;
  logic [FIFO_AW:0]   rd_ptr;
  logic [FIFO_AW-1:0] wr_idx;
  logic [FIFO_AW-1:0] rd_idx;
  logic [FIFO_AW-1:0] last_idx;
  logic               empty;
  logic               full;
  logic               pop;
  logic               err_det;
  logic               end_det;
  logic               byte_ok;
  logic               push;
  logic               ovf;
  logic               wr_en;
  logic [9:0]         push_entry;

  assign wr_idx   = wr_ptr[FIFO_AW-1:0];
  assign rd_idx   = rd_ptr[FIFO_AW-1:0];
  assign last_idx = wr_idx - FIFO_AW'(1);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) && (wr_idx == rd_idx);
  assign pop      = !empty && i_utmi_rx_lp_ready;

  assign err_det  = i_utmi_rx_rxerror && i_utmi_rx_rxactive;
  assign end_det  = rxactive_d && !i_utmi_rx_rxactive;
  assign byte_ok  = i_utmi_rx_rxvalid && !i_utmi_rx_rxerror && i_utmi_rx_rxactive;

  // Error and end both close the frame with whatever sits in the hold register.
  always_comb begin
    push       = 1'b0;
    push_entry = {h_sop, 1'b0, h_data};
    if (state == RECV) begin
      if (err_det || end_det) begin
        push       = h_valid;
        push_entry = {h_sop, 1'b1, h_data};
      end else if (byte_ok) begin
        push = h_valid;
      end
    end
  end

  assign ovf   = push && full && !pop;
  assign wr_en = push && !ovf;

  always_ff @(posedge i_utmi_rx_clk or negedge i_utmi_rx_rst_n) begin
    if (!i_utmi_rx_rst_n) begin
      state               <= IDLE;
      rxactive_d          <= 1'b0;
      armed               <= 1'b0;
      first_flag          <= 1'b0;
      h_valid             <= 1'b0;
      h_sop               <= 1'b0;
      h_data              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      mem                 <= '{default: '0};
      o_utmi_rx_pkt_error <= 1'b0;
      o_utmi_rx_overflow  <= 1'b0;
    end else begin
      rxactive_d          <= i_utmi_rx_rxactive;
      o_utmi_rx_pkt_error <= 1'b0;
      o_utmi_rx_overflow  <= 1'b0;
      // A packet already in flight at reset release is skipped until RxActive drops.
      if (!i_utmi_rx_rxactive) armed <= 1'b1;

      if (pop) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      if (wr_en) begin
        mem[wr_idx] <= push_entry;
        wr_ptr      <= wr_ptr + (FIFO_AW+1)'(1);
      end
      // Close the frame on the newest stored entry so downstream never sees an open packet.
      if (ovf) begin
        mem[last_idx][8]   <= 1'b1;
        o_utmi_rx_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_utmi_rx_rxactive && armed) begin
            state      <= RECV;
            first_flag <= 1'b1;
            h_valid    <= 1'b0;
          end
        end
        RECV: begin
          if (err_det) begin
            o_utmi_rx_pkt_error <= 1'b1;
            h_valid             <= 1'b0;
            state               <= DISCARD;
          end else if (end_det) begin
            h_valid <= 1'b0;
            state   <= ovf ? DISCARD : IDLE;
          end else if (byte_ok) begin
            if (ovf) begin
              h_valid <= 1'b0;
              state   <= DISCARD;
            end else begin
              h_valid    <= 1'b1;
              h_sop      <= first_flag;
              h_data     <= i_utmi_rx_data;
              first_flag <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (!i_utmi_rx_rxactive) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_utmi_rx_lp_data  = mem[rd_idx][7:0];
  assign o_utmi_rx_lp_sop   = mem[rd_idx][9];
  assign o_utmi_rx_lp_eop   = mem[rd_idx][8];
  assign o_utmi_rx_lp_valid = !empty;
  assign o_utmi_rx_busy     = rxactive_d | h_valid | !empty | (state != IDLE);

endmodule

// File: tb/tb_utmi_rx.sv
// Self-checking bench for utmi_rx: queue-based packet model checked every cycle,
// plus literal per-scenario beat lists that pin the model.
module tb_utmi_rx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxactive = 1'b0;
  logic       rxvalid = 1'b0;
  logic       rxerror = 1'b0;
  logic [7:0] data = '0;
  logic       lp_ready = 1'b1;
  logic [7:0] lp_data;
  logic       lp_sop;
  logic       lp_eop;
  logic       lp_valid;
  logic       pkt_error;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad = 0;
  bit tog = 1'b0;

  utmi_rx #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .i_utmi_rx_clk      (clk),
    .i_utmi_rx_rst_n    (rst_n),
    .i_utmi_rx_rxactive (rxactive),
    .i_utmi_rx_rxvalid  (rxvalid),
    .i_utmi_rx_rxerror  (rxerror),
    .i_utmi_rx_data     (data),
    .i_utmi_rx_lp_ready (lp_ready),
    .o_utmi_rx_lp_data  (lp_data),
    .o_utmi_rx_lp_sop   (lp_sop),
    .o_utmi_rx_lp_eop   (lp_eop),
    .o_utmi_rx_lp_valid (lp_valid),
    .o_utmi_rx_pkt_error(pkt_error),
    .o_utmi_rx_overflow (overflow),
    .o_utmi_rx_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stored beats {sop,eop,data}, pending byte, and packet mode (0 idle, 1 in packet, 2 dropping).
  logic [9:0] m_q[$];
  int         m_mode = 0;
  bit         m_armed = 1'b0;
  bit         m_actd = 1'b0;
  bit         m_hv = 1'b0;
  logic [9:0] m_hold = '0;
  bit         m_first = 1'b0;
  bit         m_perr = 1'b0;
  bit         m_ovf = 1'b0;

  initial begin
    bit         do_pop, need, take, closing;
    logic [9:0] tmp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_mode = 0; m_armed = 1'b0; m_actd = 1'b0; m_hv = 1'b0;
        m_first = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
      end else begin
        m_perr = 1'b0; m_ovf = 1'b0;
        do_pop = (m_q.size() != 0) && lp_ready;
        need = 1'b0; take = 1'b0; closing = 1'b0;
        if (m_mode == 0) begin
          if (rxactive && m_armed) begin m_mode = 1; m_first = 1'b1; m_hv = 1'b0; end
        end else if (m_mode == 1) begin
          if (rxerror && rxactive) begin
            m_perr = 1'b1; need = m_hv; closing = 1'b1; m_mode = 2;
          end else if (m_actd && !rxactive) begin
            need = m_hv; closing = 1'b1; m_mode = 0;
          end else if (rxvalid && rxactive) begin
            need = m_hv; take = 1'b1;
          end
        end else if (!rxactive) begin
          m_mode = 0;
        end
        tmp = m_hold;
        tmp[8] = closing;
        if (need && m_q.size() == DEPTH && !do_pop) begin
          m_ovf = 1'b1;
          m_q[m_q.size()-1] = m_q[m_q.size()-1] | 10'h100;
          m_hv = 1'b0; take = 1'b0; m_mode = 2;
        end else begin
          if (do_pop) void'(m_q.pop_front());
          if (need) m_q.push_back(tmp);
        end
        if (closing) m_hv = 1'b0;
        if (take) begin
          m_hold = {m_first, 1'b0, data};
          m_hv = 1'b1; m_first = 1'b0;
        end
        if (!rxactive) m_armed = 1'b1;
        m_actd = rxactive;
      end
    end
  end

  logic [9:0] log_q[$];
  int n_perr = 0;
  int n_ovf = 0;

  initial begin
    logic [9:0] head;
    bit         exp_busy;
    forever begin
      @(negedge clk);
      chk("lp_valid", 32'(lp_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        head = m_q[0];
        chk("lp_beat", 32'({lp_sop, lp_eop, lp_data}), 32'(head));
      end
      chk("pkt_error", 32'(pkt_error), 32'(m_perr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      exp_busy = m_actd || m_hv || (m_q.size() != 0) || (m_mode != 0);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (rst_n) begin
        if (lp_valid && lp_ready) log_q.push_back({lp_sop, lp_eop, lp_data});
        if (pkt_error) n_perr++;
        if (overflow) n_ovf++;
      end
    end
  end

  task automatic drive(input logic a, input logic v, input logic e, input logic [7:0] d);
    if (tog) lp_ready = ~lp_ready;
    rxactive = a; rxvalid = v; rxerror = e; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy === 1'b1; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_timeout", 32'(busy), 32'(0));
  endtask

  logic [9:0] exp_q[$];
  int lb, pb, ob;

  task automatic mark();
    lb = log_q.size(); pb = n_perr; ob = n_ovf;
    exp_q.delete();
  endtask

  task automatic check_beats(input string name, input int want_perr, input int want_ovf);
    logic [31:0] got;
    chk({name, "_count"}, log_q.size() - lb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (lb + i < log_q.size()) ? 32'(log_q[lb+i]) : 32'hdead_beef;
      chk({name, "_beat"}, got, 32'(exp_q[i]));
    end
    chk({name, "_perr"}, n_perr - pb, want_perr);
    chk({name, "_ovf"}, n_ovf - ob, want_ovf);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_valid"}, 32'(lp_valid), 0);
    chk({name, "_data"}, 32'({lp_sop, lp_eop, lp_data}), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_pulses"}, 32'({pkt_error, overflow}), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'h00);

    // 1: three-byte packet, ready high
    mark(); lp_ready = 1'b1; tog = 1'b0;
    drive(1, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h69); drive(1, 1, 0, 8'h00); drive(1, 1, 0, 8'h10);
    drive(0, 0, 0, 8'h00);
    drain();
    exp_q.push_back(10'h269); exp_q.push_back(10'h000); exp_q.push_back(10'h110);
    check_beats("t1", 0, 0);

    // 2: single-byte ACK, then zero-byte packet
    mark();
    drive(1, 0, 0, 8'h00); drive(1, 1, 0, 8'hD2); drive(0, 0, 0, 8'h00);
    drain();
    exp_q.push_back(10'h3D2);
    check_beats("t2a", 0, 0);
    mark();
    drive(1, 0, 0, 8'h00); drive(1, 0, 0, 8'h00); drive(0, 0, 0, 8'h00);
    drain();
    check_beats("t2b", 0, 0);

    // 3: RxError after second byte, held high, then a byte that must be dropped
    mark();
    drive(1, 0, 0, 8'h00); drive(1, 1, 0, 8'hC3); drive(1, 1, 0, 8'h11);
    drive(1, 0, 1, 8'h00); drive(1, 0, 1, 8'h00); drive(1, 1, 0, 8'h22);
    drive(0, 0, 0, 8'h00);
    drain();
    exp_q.push_back(10'h2C3); exp_q.push_back(10'h111);
    check_beats("t3", 1, 0);

    // 4: stalled downstream overflows on the sixth byte
    mark(); lp_ready = 1'b0;
    drive(1, 0, 0, 8'h00);
    for (int b = 8'h11; b <= 8'h16; b++) drive(1, 1, 0, 8'(b));
    drive(0, 0, 0, 8'h00);
    repeat (3) drive(0, 0, 0, 8'h00);
    lp_ready = 1'b1;
    drain();
    exp_q.push_back(10'h211); exp_q.push_back(10'h012);
    exp_q.push_back(10'h013); exp_q.push_back(10'h114);
    check_beats("t4", 0, 1);

    // 5: back-to-back packets with toggling ready
    mark(); lp_ready = 1'b0; tog = 1'b1;
    drive(1, 0, 0, 8'h00);
    drive(1, 1, 0, 8'hA5); drive(1, 1, 0, 8'h01); drive(1, 1, 0, 8'h02);
    drive(0, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h4B); drive(1, 1, 0, 8'h55);
    drive(0, 0, 0, 8'h00);
    drain();
    tog = 1'b0; lp_ready = 1'b1;
    exp_q.push_back(10'h2A5); exp_q.push_back(10'h001); exp_q.push_back(10'h102);
    exp_q.push_back(10'h24B); exp_q.push_back(10'h155);
    check_beats("t5", 0, 0);

    // 6: reset mid-packet, released while RxActive is still high
    drive(1, 0, 0, 8'h00); drive(1, 1, 0, 8'hAA); drive(1, 1, 0, 8'hBB);
    rst_n = 1'b0;
    #2;
    check_reset_state("midrst");
    drive(1, 0, 0, 8'h00); drive(1, 1, 0, 8'h33);
    rst_n = 1'b1;
    mark();
    drive(1, 1, 0, 8'hCC); drive(1, 1, 0, 8'hDD);
    drive(0, 0, 0, 8'h00);
    drain();
    check_beats("t6a", 0, 0);
    mark();
    drive(1, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h2D); drive(1, 1, 0, 8'h05); drive(1, 1, 0, 8'h08);
    drive(0, 0, 0, 8'h00);
    drain();
    exp_q.push_back(10'h22D); exp_q.push_back(10'h005); exp_q.push_back(10'h108);
    check_beats("t6b", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
